// File: rtl/mxint8_stream_packer.sv
// MXINT8 receive-side packer: collects one E8M0 scale beat plus BLOCK_SIZE int8
// element beats into a parallel block, with zero count, NaN flag and framing checks.
module mxint8_stream_packer #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ELEM_WIDTH-1:0]              in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [SCALE_WIDTH-1:0]             out_scale,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0]   out_elements,
    output logic [$clog2(BLOCK_SIZE):0]        out_zero_num,
    output logic                               out_is_nan,
    output logic                               frame_err
);

    localparam int IDXW = $clog2(BLOCK_SIZE);
    localparam int ZW   = $clog2(BLOCK_SIZE) + 1;

    typedef enum logic [1:0] {
        S_SCALE,
        S_ELEMS,
        S_FULL,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [IDXW-1:0]       r_idx;
    logic [SCALE_WIDTH-1:0] r_scale;
    logic                  r_is_nan;
    logic [ZW-1:0]         r_zero_cnt;
    logic [ELEM_WIDTH-1:0] r_elem [BLOCK_SIZE];
    logic                  r_frame_err;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_frame_err_next;
    logic                  w_last_elem;
    logic                  w_xfer;

    assign w_last_elem = (r_idx == IDXW'(BLOCK_SIZE - 1));
    assign w_xfer      = in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SCALE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake flags depend on state only; transitions use in_valid directly
    // because every state that advances on an input beat has in_ready high.
    always_comb begin
        w_next_state     = r_state;
        w_in_ready       = 1'b0;
        w_out_valid      = 1'b0;
        w_frame_err_next = 1'b0;
        case (r_state)
            S_SCALE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last) begin
                        w_frame_err_next = 1'b1;
                    end else begin
                        w_next_state = S_ELEMS;
                    end
                end
            end
            S_ELEMS: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    if (w_last_elem) begin
                        if (in_last) begin
                            w_next_state = S_FULL;
                        end else begin
                            w_frame_err_next = 1'b1;
                            w_next_state     = S_DRAIN;
                        end
                    end else if (in_last) begin
                        w_frame_err_next = 1'b1;
                        w_next_state     = S_SCALE;
                    end
                end
            end
            S_FULL: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_SCALE;
                end
            end
            S_DRAIN: begin
                w_in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_next_state = S_SCALE;
                end
            end
            default: begin
                w_next_state = S_SCALE;
            end
        endcase
    end

    // Datapath only moves on accepted beats, so everything is frozen in FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_scale     <= '0;
            r_is_nan    <= 1'b0;
            r_zero_cnt  <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                r_elem[i] <= '0;
            end
        end else begin
            r_frame_err <= w_frame_err_next;
            if (w_xfer) begin
                case (r_state)
                    S_SCALE: begin
                        if (!in_last) begin
                            r_scale    <= SCALE_WIDTH'(in_data);
                            r_is_nan   <= (SCALE_WIDTH'(in_data) == {SCALE_WIDTH{1'b1}});
                            r_zero_cnt <= '0;
                            r_idx      <= '0;
                        end
                    end
                    S_ELEMS: begin
                        r_elem[r_idx] <= in_data;
                        if (in_data == '0) begin
                            r_zero_cnt <= r_zero_cnt + ZW'(1);
                        end
                        r_idx <= w_last_elem ? '0 : r_idx + IDXW'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Element 0 lands in the most significant byte of the packed vector.
    always_comb begin
        out_elements = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            out_elements[(BLOCK_SIZE - i) * ELEM_WIDTH - 1 -: ELEM_WIDTH] = r_elem[i];
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_scale    = r_scale;
    assign out_zero_num = r_zero_cnt;
    assign out_is_nan   = r_is_nan;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_mxint8_stream_packer.sv
// Self-checking bench for mxint8_stream_packer: directed framing scenarios plus
// randomized blocks compared against an array-based reference model.
module tb_mxint8_stream_packer;

    localparam int BS = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_scale;
    logic [BS*8-1:0]   out_elements;
    logic [5:0]        out_zero_num;
    logic              out_is_nan;
    logic              frame_err;

    int                vectors;
    int                miscompares;
    int                errPulses;
    int                validCycles;

    logic [7:0]        mScale;
    logic [7:0]        mElems [BS];

    mxint8_stream_packer #(
        .BLOCK_SIZE  (BS),
        .ELEM_WIDTH  (8),
        .SCALE_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_scale    (out_scale),
        .out_elements (out_elements),
        .out_zero_num (out_zero_num),
        .out_is_nan   (out_is_nan),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) errPulses++;
        if (out_valid === 1'b1) validCycles++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic logic [BS*8-1:0] expElements();
        logic [BS*8-1:0] v;
        v = '0;
        for (int i = 0; i < BS; i++) begin
            v[(BS - i) * 8 - 1 -: 8] = mElems[i];
        end
        return v;
    endfunction

    function automatic int expZeros();
        int n;
        n = 0;
        for (int i = 0; i < BS; i++) begin
            if (mElems[i] == 8'h00) n++;
        end
        return n;
    endfunction

    task automatic fillRandom(input int zeroPct);
        for (int i = 0; i < BS; i++) begin
            if ($urandom_range(99) < zeroPct) mElems[i] = 8'h00;
            else mElems[i] = 8'($urandom_range(255));
        end
    endtask

    task automatic checkOutput(input string tag, input logic [BS*8-1:0] obs,
                               input logic [BS*8-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_scale"}, out_scale, 0);
        checkOutput({tag, "_elements"}, out_elements, 0);
        checkOutput({tag, "_zero_num"}, out_zero_num, 0);
        checkOutput({tag, "_is_nan"}, out_is_nan, 0);
        checkOutput({tag, "_frame_err"}, frame_err, 0);
    endtask

    task automatic checkFields(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_in_ready_low"}, in_ready, 0);
        checkOutput({tag, "_scale"}, out_scale, mScale);
        checkOutput({tag, "_elements"}, out_elements, expElements());
        checkOutput({tag, "_zero_num"}, out_zero_num, expZeros());
        checkOutput({tag, "_is_nan"}, out_is_nan, (mScale == 8'hFF));
    endtask

    // Drives one beat from a negedge and returns at the negedge after it transfers.
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) checkOutput("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic runBlock(input string tag, input int stall);
        int e0;
        int v0;
        int g;
        e0 = errPulses;
        v0 = validCycles;
        applyStimulus(mScale, 1'b0);
        for (int i = 0; i < BS; i++) begin
            applyStimulus(mElems[i], (i == BS - 1));
        end
        checkOutput({tag, "_latency"}, out_valid, 1);
        g = 0;
        while (out_valid !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        checkFields(tag);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(255));
            in_last  = 1'($urandom_range(1));
            @(posedge clk);
            @(negedge clk);
            checkFields({tag, "_hold"});
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_accept_valid"}, out_valid, 0);
        checkOutput({tag, "_accept_in_ready"}, in_ready, 1);
        checkOutput({tag, "_valid_cycles"}, validCycles - v0, stall + 1);
        checkOutput({tag, "_no_frame_err"}, errPulses - e0, 0);
    endtask

    initial begin
        int e0;
        int v0;
        vectors     = 0;
        miscompares = 0;
        errPulses   = 0;
        validCycles = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        errPulses   = 0;
        validCycles = 0;

        $display("[TB] ramp block");
        mScale = 8'h7F;
        for (int i = 0; i < BS; i++) mElems[i] = 8'(i);
        runBlock("ramp", 0);

        $display("[TB] all-zero block with NaN scale");
        mScale = 8'hFF;
        for (int i = 0; i < BS; i++) mElems[i] = 8'h00;
        runBlock("nan_zero", 0);

        $display("[TB] random blocks");
        for (int b = 0; b < 4; b++) begin
            mScale = (b == 2) ? 8'hFF : 8'($urandom_range(254));
            fillRandom(30);
            runBlock("rand", $urandom_range(3));
        end

        $display("[TB] backpressure");
        mScale = 8'h12;
        fillRandom(10);
        runBlock("backpressure", 10);

        $display("[TB] early in_last");
        e0 = errPulses;
        v0 = validCycles;
        applyStimulus(8'h40, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            applyStimulus(8'($urandom_range(255)), (i == 5));
        end
        checkOutput("early_err_pulse", frame_err, 1);
        checkOutput("early_no_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("early_err_once", frame_err, 0);
        checkOutput("early_in_ready", in_ready, 1);
        checkOutput("early_err_count", errPulses - e0, 1);
        checkOutput("early_valid_count", validCycles - v0, 0);
        mScale = 8'h85;
        fillRandom(25);
        runBlock("after_early", 0);

        $display("[TB] missing in_last");
        e0 = errPulses;
        v0 = validCycles;
        applyStimulus(8'h33, 1'b0);
        for (int i = 0; i < BS; i++) begin
            applyStimulus(8'($urandom_range(255)), 1'b0);
        end
        checkOutput("drain_err_pulse", frame_err, 1);
        checkOutput("drain_no_valid", out_valid, 0);
        checkOutput("drain_in_ready", in_ready, 1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("drain_err_once", frame_err, 0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'hAA, 1'b1);
        checkOutput("drain_done_in_ready", in_ready, 1);
        checkOutput("drain_err_count", errPulses - e0, 1);
        checkOutput("drain_valid_count", validCycles - v0, 0);
        mScale = 8'h01;
        fillRandom(25);
        runBlock("after_drain", 0);

        $display("[TB] async reset mid-block");
        mScale = 8'h90;
        fillRandom(40);
        e0 = errPulses;
        v0 = validCycles;
        applyStimulus(mScale, 1'b0);
        for (int i = 0; i <= 10; i++) applyStimulus(mElems[i], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("reset_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_valid_count", validCycles - v0, 0);
        checkOutput("reset_mid_err_count", errPulses - e0, 0);
        mScale = 8'h81;
        fillRandom(40);
        runBlock("after_reset", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
